// File: rtl/seg7_msg_scroller_pkg.sv
// Shared definitions for the 7-segment message scroller: glyph codes,
// segment patterns ({g,f,e,d,c,b,a}, active-high), the FSM state type and
// the default message. The GAP state is only part of the type when the
// SEG7_GAP_EN macro is defined.
package seg7_pkg;

   localparam logic [3:0] GLYPH_G = 4'd0;
   localparam logic [3:0] GLYPH_I = 4'd1;
   localparam logic [3:0] GLYPH_L = 4'd2;
   localparam logic [3:0] GLYPH_B = 4'd3;
   localparam logic [3:0] GLYPH_E = 4'd4;
   localparam logic [3:0] GLYPH_R = 4'd5;
   localparam logic [3:0] GLYPH_T = 4'd6;
   localparam logic [3:0] GLYPH_O = 4'd7;

   localparam logic [6:0] SEG_G     = 7'b1111101;
   localparam logic [6:0] SEG_I     = 7'b0000110;
   localparam logic [6:0] SEG_L     = 7'b0111000;
   localparam logic [6:0] SEG_B     = 7'b1111100;
   localparam logic [6:0] SEG_E     = 7'b1111001;
   localparam logic [6:0] SEG_R     = 7'b1010000;
   localparam logic [6:0] SEG_T     = 7'b0110001;
   localparam logic [6:0] SEG_O     = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Message "GILBERTO", glyph 0 in the least significant nibble.
   localparam logic [31:0] DEFAULT_MSG = 32'h7654_3210;

`ifdef SEG7_GAP_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1
   } state_t;
`endif

endpackage

// File: rtl/seg7_msg_scroller_if.sv
// Control and display bundle of the message scroller. The controller side
// (master) drives run/direction/restart and watches the display outputs.
interface seg7_msg_scroller_if #(
   parameter int IDX_W = 3
);
   logic             enable;
   logic             dir;
   logic             restart;
   logic [6:0]       segments;
   logic [IDX_W-1:0] glyph_idx;
   logic             wrap;

   modport master (
      output enable, dir, restart,
      input  segments, glyph_idx, wrap
   );

   modport slave (
      input  enable, dir, restart,
      output segments, glyph_idx, wrap
   );
endinterface

// File: rtl/seg7_msg_scroller_glyph_rom.sv
// Combinational glyph decoder: 4-bit code to 7-segment pattern.
// Codes 8..15 have no glyph and decode to blank.
module seg7_glyph_rom
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   // Code-to-pattern lookup.
   always_comb begin
      seg = SEG_BLANK;
      case (code)
         GLYPH_G: seg = SEG_G;
         GLYPH_I: seg = SEG_I;
         GLYPH_L: seg = SEG_L;
         GLYPH_B: seg = SEG_B;
         GLYPH_E: seg = SEG_E;
         GLYPH_R: seg = SEG_R;
         GLYPH_T: seg = SEG_T;
         GLYPH_O: seg = SEG_O;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_msg_scroller.sv
// Steps a MSG_LEN-glyph message onto one 7-segment digit, one glyph per
// TICK_DIV clocks, with pause, direction, restart and a wrap strobe.
// Optional feature macro: SEG7_GAP_EN inserts a blank GAP step of TICK_DIV
// clocks between glyphs; index advance and wrap then happen on GAP exit.
//
// state | meaning
// IDLE  | display blank, waiting for enable
// SHOW  | current glyph displayed, prescaler running while enabled
// GAP   | blank spacer between glyphs (SEG7_GAP_EN only)
module seg7_msg_scroller
   import seg7_pkg::*;
#(
   parameter int                   MSG_LEN  = 8,
   parameter int                   TICK_DIV = 12_000_000,
   parameter logic [4*MSG_LEN-1:0] MSG      = DEFAULT_MSG
) (
   input logic                clk,
   input logic                rst,
   seg7_msg_scroller_if.slave bus
);

   localparam int IDX_W = $clog2(MSG_LEN);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             wrap, wrap_nxt;
   logic [6:0]       segments;

   logic [IDX_W-1:0] idx_adv;
   logic             adv_wraps;
   logic             step_end;
   logic [3:0]       glyph_code;
   logic [6:0]       glyph_seg;

   assign step_end   = (cnt == CNT_LAST);
   assign glyph_code = MSG[{idx, 2'b00} +: 4];

   seg7_glyph_rom u_rom (
      .code (glyph_code),
      .seg  (glyph_seg)
   );

   // Neighbour index in the current direction, wrapping at both ends.
   always_comb begin
      idx_adv   = idx;
      adv_wraps = 1'b0;
      if (bus.dir) begin
         if (idx == '0) begin
            idx_adv   = IDX_LAST;
            adv_wraps = 1'b1;
         end else begin
            idx_adv = idx - IDX_W'(1);
         end
      end else begin
         if (idx == IDX_LAST) begin
            idx_adv   = '0;
            adv_wraps = 1'b1;
         end else begin
            idx_adv = idx + IDX_W'(1);
         end
      end
   end

   // Next-state logic; restart outranks any step end in the same clock.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      wrap_nxt  = 1'b0;
      if (bus.restart) begin
         idx_nxt   = '0;
         cnt_nxt   = '0;
         state_nxt = bus.enable ? ST_SHOW : ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.enable) begin
                  state_nxt = ST_SHOW;
                  idx_nxt   = '0;
                  cnt_nxt   = '0;
               end
            end
            ST_SHOW: begin
               if (bus.enable) begin
                  if (step_end) begin
                     cnt_nxt = '0;
`ifdef SEG7_GAP_EN
                     state_nxt = ST_GAP;
`else
                     idx_nxt  = idx_adv;
                     wrap_nxt = adv_wraps;
`endif
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
            end
`ifdef SEG7_GAP_EN
            ST_GAP: begin
               if (bus.enable) begin
                  if (step_end) begin
                     cnt_nxt   = '0;
                     state_nxt = ST_SHOW;
                     idx_nxt   = idx_adv;
                     wrap_nxt  = adv_wraps;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
            end
`endif
            default: begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // FSM, index, prescaler and wrap strobe registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         cnt   <= '0;
         wrap  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
         wrap  <= wrap_nxt;
      end
   end

   // Output register: glyph of the current index while showing, else blank.
   always_ff @(posedge clk) begin
      if (rst) begin
         segments <= SEG_BLANK;
      end else if (state == ST_SHOW) begin
         segments <= glyph_seg;
      end else begin
         segments <= SEG_BLANK;
      end
   end

   assign bus.segments  = segments;
   assign bus.glyph_idx = idx;
   assign bus.wrap      = wrap;

endmodule

// File: tb/tb_seg7_msg_scroller.sv
// Scoreboard bench for seg7_msg_scroller: each driven cycle runs a
// message-level reference model and queues the expected outputs; a monitor
// compares them one clock later.
module tb_seg7_msg_scroller;

   localparam int MSG_LEN = 8;
`ifdef SEG7_GAP_EN
   localparam int TICK_DIV = 1;
   localparam bit HAS_GAP  = 1'b1;
`else
   localparam int TICK_DIV = 4;
   localparam bit HAS_GAP  = 1'b0;
`endif

   typedef struct {
      logic [6:0] seg;
      logic [2:0] idx;
      logic       wrap;
   } exp_t;

   logic clk;
   logic rst;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: mode 0 = blank/waiting, 1 = showing, 2 = spacer.
   int         m_mode = 0;
   int         m_pos = 0;
   int         m_elapsed = 0;
   logic [6:0] m_seg = 7'b0;
   logic       m_wrap = 1'b0;

   seg7_msg_scroller_if #(.IDX_W(3)) bus ();

   seg7_msg_scroller #(
      .MSG_LEN  (MSG_LEN),
      .TICK_DIV (TICK_DIV),
      .MSG      (32'h7654_3210)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [6:0] letter_pattern(input int pos);
      string      text;
      byte        c;
      logic [6:0] p;
      text = "GILBERTO";
      c    = text[pos];
      case (c)
         "G": p = 7'b1111101;
         "I": p = 7'b0000110;
         "L": p = 7'b0111000;
         "B": p = 7'b1111100;
         "E": p = 7'b1111001;
         "R": p = 7'b1010000;
         "T": p = 7'b0110001;
         "O": p = 7'b0111111;
         default: p = 7'b0;
      endcase
      return p;
   endfunction

   task automatic model_step(input bit r, input bit e, input bit d, input bit s);
      logic [6:0] shown;
      int         nxt;
      shown  = (m_mode == 1) ? letter_pattern(m_pos) : 7'b0;
      m_wrap = 1'b0;
      if (r) begin
         m_mode = 0; m_pos = 0; m_elapsed = 0; shown = 7'b0;
      end else if (s) begin
         m_pos = 0; m_elapsed = 0; m_mode = e ? 1 : 0;
      end else if (m_mode == 0) begin
         if (e) begin m_mode = 1; m_pos = 0; m_elapsed = 0; end
      end else if (e) begin
         if (m_elapsed == TICK_DIV - 1) begin
            m_elapsed = 0;
            if (HAS_GAP && m_mode == 1) begin
               m_mode = 2;
            end else begin
               nxt    = d ? (m_pos + MSG_LEN - 1) % MSG_LEN : (m_pos + 1) % MSG_LEN;
               m_wrap = d ? (m_pos == 0) : (nxt == 0);
               m_pos  = nxt;
               m_mode = 1;
            end
         end else begin
            m_elapsed++;
         end
      end
      m_seg = shown;
   endtask

   task automatic drive(input bit r, input bit e, input bit d, input bit s);
      exp_t x;
      @(negedge clk);
      rst         = r;
      bus.enable  = e;
      bus.dir     = d;
      bus.restart = s;
      model_step(r, e, d, s);
      x.seg  = m_seg;
      x.idx  = 3'(m_pos);
      x.wrap = m_wrap;
      q.push_back(x);
   endtask

   // Monitor: compares each queued expectation just after its clock edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (bus.segments !== x.seg) begin
               errors++;
               $display("FAIL segments t=%0t got %b want %b", $time, bus.segments, x.seg);
            end
            checks++;
            if (bus.glyph_idx !== x.idx) begin
               errors++;
               $display("FAIL glyph_idx t=%0t got %0d want %0d", $time, bus.glyph_idx, x.idx);
            end
            checks++;
            if (bus.wrap !== x.wrap) begin
               errors++;
               $display("FAIL wrap t=%0t got %b want %b", $time, bus.wrap, x.wrap);
            end
         end
      end
   end

   initial begin
      int guard;
      bit dir_r;
      rst         = 1'b1;
      bus.enable  = 1'b0;
      bus.dir     = 1'b0;
      bus.restart = 1'b0;

      // Reset, then idle with enable low.
      repeat (3) drive(1, 0, 0, 0);
      repeat (20) drive(0, 0, 0, 0);

      // Forward through the whole message and past the wrap.
      repeat (8 * MSG_LEN * TICK_DIV / 4 + 40) drive(0, 1, 0, 0);

      // Run forward to index 0, then reverse across the wrap.
      guard = 0;
      while (!(m_pos == 0 && m_mode == 1 && m_elapsed == 0) && guard < 200) begin
         drive(0, 1, 0, 0);
         guard++;
      end
      repeat (3 * TICK_DIV * 2 + 4) drive(0, 1, 1, 0);

      // Pause mid-glyph at prescaler value 2 (when the prescaler reaches it).
      guard = 0;
      while (!(m_mode == 1 && m_elapsed == 2 % TICK_DIV) && guard < 200) begin
         drive(0, 1, 0, 0);
         guard++;
      end
      repeat (10) drive(0, 0, 0, 0);
      repeat (2 * TICK_DIV + 3) drive(0, 1, 0, 0);

      // Restart on the last prescaler clock at index 5.
      guard = 0;
      while (!(m_pos == 5 && m_mode == 1 && m_elapsed == TICK_DIV - 1) && guard < 400) begin
         drive(0, 1, 0, 0);
         guard++;
      end
      checks++;
      if (guard >= 400) begin
         errors++;
         $display("FAIL restart_setup model never reached idx 5 (guard %0d limit 400)", guard);
      end
      drive(0, 1, 0, 1);
      repeat (TICK_DIV + 3) drive(0, 1, 0, 0);

      // Restart with enable low returns to blank; mid-step reset.
      drive(0, 0, 0, 1);
      repeat (3) drive(0, 0, 0, 0);
      repeat (TICK_DIV + 1) drive(0, 1, 1, 0);
      drive(1, 1, 0, 0);
      repeat (3) drive(0, 1, 0, 0);

      // Randomised run.
      dir_r = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) dir_r = ~dir_r;
         drive(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 9) != 0),
               dir_r,
               ($urandom_range(0, 59) == 0));
      end
      repeat (4) drive(0, 1, 0, 0);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain %0d expectations left, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
